// File: rtl/hex_keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner: FSM states,
// matrix dimensions, key-map lookup and small decode helpers.
package hex_keypad_pkg;

   localparam int ROW_W     = 4;
   localparam int COL_W     = 4;
   localparam int COL_IDX_W = $clog2(COL_W);
   localparam int ROW_IDX_W = $clog2(ROW_W);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } scan_state_t;

   // Key at matrix position {row, col} to its hex digit.
   function automatic logic [3:0] key_map(input logic [ROW_IDX_W-1:0] row,
                                          input logic [COL_IDX_W-1:0] col);
      logic [3:0] code_s;
      case ({row, col})
         4'd0:    code_s = 4'h1;
         4'd1:    code_s = 4'h2;
         4'd2:    code_s = 4'h3;
         4'd3:    code_s = 4'hA;
         4'd4:    code_s = 4'h4;
         4'd5:    code_s = 4'h5;
         4'd6:    code_s = 4'h6;
         4'd7:    code_s = 4'hB;
         4'd8:    code_s = 4'h7;
         4'd9:    code_s = 4'h8;
         4'd10:   code_s = 4'h9;
         4'd11:   code_s = 4'hC;
         4'd12:   code_s = 4'hE;
         4'd13:   code_s = 4'h0;
         4'd14:   code_s = 4'hF;
         4'd15:   code_s = 4'hD;
         default: code_s = 4'h0;
      endcase
      return code_s;
   endfunction

   // Lowest-index row reading low; ties within a column go to the lowest row.
   function automatic logic [ROW_IDX_W-1:0] lowest_low_row(input logic [ROW_W-1:0] rows);
      logic [ROW_IDX_W-1:0] idx_s;
      if (!rows[0]) begin
         idx_s = 2'd0;
      end else if (!rows[1]) begin
         idx_s = 2'd1;
      end else if (!rows[2]) begin
         idx_s = 2'd2;
      end else begin
         idx_s = 2'd3;
      end
      return idx_s;
   endfunction

   // Active-low one-cold column drive for a column index.
   function automatic logic [COL_W-1:0] col_drive(input logic [COL_IDX_W-1:0] col);
      return ~(4'b0001 << col);
   endfunction

endpackage

// File: rtl/hex_keypad_scanner_if.sv
// Key handshake bundle between the keypad scanner (master) and a digit consumer (slave).
interface hex_keypad_scanner_if;

   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack;
   logic       key_down;
   logic       overrun;

   modport master (
      output key_code,
      output key_valid,
      output key_down,
      output overrun,
      input  key_ack
   );

   modport slave (
      input  key_code,
      input  key_valid,
      input  key_down,
      input  overrun,
      output key_ack
   );

endinterface

// File: rtl/hex_keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows; idles at all-ones
// (no key) so reset never looks like a press.
module keypad_row_sync
   import hex_keypad_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic [ROW_W-1:0] row_in,
   output logic [ROW_W-1:0] rs
);

   logic [ROW_W-1:0] meta_r;
   logic [ROW_W-1:0] sync_r;

   // Two-stage capture of the raw rows into the clock domain.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta_r <= {ROW_W{1'b1}};
         sync_r <= {ROW_W{1'b1}};
      end else begin
         meta_r <= row_in;
         sync_r <= meta_r;
      end
   end

   assign rs = sync_r;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column drive, latches the first
// low row found at the end of a column dwell, debounces press and release on
// that single key, and hands the hex digit out with a valid/ack handshake.
module hex_keypad_scanner
   import hex_keypad_pkg::*;
#(
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ROW_W-1:0]     row_in,
   output logic [COL_W-1:0]     col_out,
   hex_keypad_scanner_if.master kp
);

   localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [ROW_W-1:0]     rs_s;
   scan_state_t          state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [COL_IDX_W-1:0] col_r;
   logic [ROW_IDX_W-1:0] row_r;
   logic [COL_W-1:0]     col_out_r;
   logic [3:0]           key_code_r;
   logic                 key_valid_r;
   logic                 key_down_r;
   logic                 overrun_r;

   logic                 row_level_s;
   logic [COL_IDX_W-1:0] next_col_s;
   logic                 accept_s;

   keypad_row_sync u_row_sync (
      .clock  (clock),
      .reset  (reset),
      .row_in (row_in),
      .rs     (rs_s)
   );

   // Level of the latched row, the following column, and the press-accept strobe.
   always_comb begin
      row_level_s = rs_s[row_r];
      next_col_s  = col_r + 2'd1;
      if ((state_r == PRESS_DB) && !row_level_s && (cnt_r == DB_LAST)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Scan/debounce FSM with its counters, column drive and key handshake.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= SCAN;
         cnt_r       <= CNT_ZERO;
         col_r       <= 2'd0;
         row_r       <= 2'd0;
         col_out_r   <= 4'b1110;
         key_code_r  <= 4'h0;
         key_valid_r <= 1'b0;
         key_down_r  <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         case (state_r)
            SCAN: begin
               if (cnt_r == SCAN_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (rs_s != 4'b1111) begin
                     // Column drive stays on the latched column until release.
                     row_r   <= lowest_low_row(rs_s);
                     state_r <= PRESS_DB;
                  end else begin
                     col_r     <= next_col_s;
                     col_out_r <= col_drive(next_col_s);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            PRESS_DB: begin
               if (!row_level_s) begin
                  if (cnt_r == DB_LAST) begin
                     cnt_r      <= CNT_ZERO;
                     key_down_r <= 1'b1;
                     state_r    <= HELD;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end else begin
                  // Press did not survive debounce: resume scanning after it.
                  cnt_r     <= CNT_ZERO;
                  col_r     <= next_col_s;
                  col_out_r <= col_drive(next_col_s);
                  state_r   <= SCAN;
               end
            end
            HELD: begin
               if (row_level_s) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= REL_DB;
               end else begin
                  cnt_r <= CNT_ZERO;
               end
            end
            REL_DB: begin
               if (row_level_s) begin
                  if (cnt_r == DB_LAST) begin
                     cnt_r      <= CNT_ZERO;
                     key_down_r <= 1'b0;
                     col_r      <= next_col_s;
                     col_out_r  <= col_drive(next_col_s);
                     state_r    <= SCAN;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end else begin
                  // Any bounce back low restarts the release count.
                  cnt_r <= CNT_ZERO;
               end
            end
            default: begin
               cnt_r     <= CNT_ZERO;
               col_r     <= 2'd0;
               col_out_r <= 4'b1110;
               state_r   <= SCAN;
            end
         endcase

         // First unacknowledged key wins; a same-cycle ack makes room for the new one.
         if (accept_s) begin
            if (!key_valid_r || kp.key_ack) begin
               key_code_r  <= key_map(row_r, col_r);
               key_valid_r <= 1'b1;
            end else begin
               overrun_r <= 1'b1;
            end
         end else if (kp.key_ack && key_valid_r) begin
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
         end else begin
            key_valid_r <= key_valid_r;
         end
      end
   end

   assign col_out      = col_out_r;
   assign kp.key_code  = key_code_r;
   assign kp.key_valid = key_valid_r;
   assign kp.key_down  = key_down_r;
   assign kp.overrun   = overrun_r;

endmodule
